// File: rtl/sd_block_pkg.sv
// Shared types and constants for the SD block-buffer responder.
// One block is 512 bytes, addressed by a 9-bit byte index.
package sd_block_pkg;

    localparam int         BLK_BYTES = 512;
    localparam int         IDX_W     = 9;
    localparam logic [7:0] RD_FILL   = 8'hFF;

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(BLK_BYTES - 1);

    typedef enum logic [3:0] {
        IDLE,
        ACKWAIT,
        RD_REQ,
        RD_STB,
        WR_ADDR,
        WR_WAIT,
        WR_CAP,
        WR_MEM,
        FINISH
    } state_e;

endpackage

// File: rtl/sd_block_responder.sv
// Device end of the SD block-buffer handshake: moves one 512-byte block
// between the initiator buffer and a stall-capable backing byte store.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for sd_rd/sd_wr while sd_ack is low
// ACKWAIT | delay counter running down to the sd_ack rise
// RD_REQ  | backing store read outstanding for byte idx
// RD_STB  | one-cycle sd_buff_wr strobe of the fetched byte
// WR_ADDR | present idx on sd_buff_addr
// WR_WAIT | initiator RAM registers the address
// WR_CAP  | sd_buff_din sampled into mem_wdata
// WR_MEM  | backing store write outstanding for byte idx
// FINISH  | last cycle with sd_ack high
module sd_block_responder
    import sd_block_pkg::*;
#(
    parameter int LBA_W     = 4,
    parameter int ACK_DELAY = 4
) (
    input  logic             clk_sys,
    input  logic             RESET_n,
    input  logic [31:0]      sd_lba,
    input  logic             sd_rd,
    input  logic             sd_wr,
    output logic             sd_ack,
    output logic [8:0]       sd_buff_addr,
    output logic [7:0]       sd_buff_dout,
    input  logic [7:0]       sd_buff_din,
    output logic             sd_buff_wr,
    output logic [LBA_W+8:0] mem_addr,
    output logic             mem_rd,
    output logic             mem_wr,
    output logic [7:0]       mem_wdata,
    input  logic [7:0]       mem_rdata,
    input  logic             mem_ready,
    output logic             busy,
    output logic             oob_err
);

    localparam int               CNT_W    = (ACK_DELAY > 1) ? $clog2(ACK_DELAY) : 1;
    localparam logic [CNT_W-1:0] ACK_LOAD = CNT_W'(ACK_DELAY - 1);

    state_e             state_q, state_d;
    logic [LBA_W-1:0]   lba_q, lba_d;
    logic               dir_rd_q, dir_rd_d;
    logic               oob_q, oob_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ack_q, ack_d;
    logic [7:0]         dout_q, dout_d;
    logic [IDX_W-1:0]   baddr_q, baddr_d;
    logic [7:0]         wdata_q, wdata_d;
    logic               oob_err_q, oob_err_d;
    logic               req_oob;

    // Any address bit above the store width makes the block out of range.
    assign req_oob = (sd_lba >> LBA_W) != 32'd0;

    always_ff @(posedge clk_sys or negedge RESET_n) begin
        if (!RESET_n) begin
            state_q   <= IDLE;
            lba_q     <= '0;
            dir_rd_q  <= 1'b0;
            oob_q     <= 1'b0;
            idx_q     <= '0;
            cnt_q     <= '0;
            ack_q     <= 1'b0;
            dout_q    <= '0;
            baddr_q   <= '0;
            wdata_q   <= '0;
            oob_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            lba_q     <= lba_d;
            dir_rd_q  <= dir_rd_d;
            oob_q     <= oob_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            ack_q     <= ack_d;
            dout_q    <= dout_d;
            baddr_q   <= baddr_d;
            wdata_q   <= wdata_d;
            oob_err_q <= oob_err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        lba_d      = lba_q;
        dir_rd_d   = dir_rd_q;
        oob_d      = oob_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        ack_d      = ack_q;
        dout_d     = dout_q;
        baddr_d    = baddr_q;
        wdata_d    = wdata_q;
        oob_err_d  = oob_err_q;
        sd_buff_wr = 1'b0;
        mem_rd     = 1'b0;
        mem_wr     = 1'b0;

        case (state_q)
            IDLE: begin
                if ((sd_rd || sd_wr) && !ack_q) begin
                    lba_d     = sd_lba[LBA_W-1:0];
                    dir_rd_d  = sd_rd;
                    oob_d     = req_oob;
                    oob_err_d = oob_err_q | req_oob;
                    idx_d     = '0;
                    cnt_d     = ACK_LOAD;
                    state_d   = ACKWAIT;
                end
            end
            ACKWAIT: begin
                if (cnt_q == '0) begin
                    ack_d   = 1'b1;
                    state_d = dir_rd_q ? RD_REQ : WR_ADDR;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RD_REQ: begin
                mem_rd = !oob_q;
                if (oob_q || mem_ready) begin
                    dout_d  = oob_q ? RD_FILL : mem_rdata;
                    baddr_d = idx_q;
                    state_d = RD_STB;
                end
            end
            RD_STB: begin
                sd_buff_wr = 1'b1;
                if (idx_q == IDX_LAST) begin
                    state_d = FINISH;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = RD_REQ;
                end
            end
            WR_ADDR: begin
                baddr_d = idx_q;
                state_d = WR_WAIT;
            end
            WR_WAIT: begin
                state_d = WR_CAP;
            end
            WR_CAP: begin
                // Two edges after the address moved: registered-read data is stable.
                wdata_d = sd_buff_din;
                state_d = WR_MEM;
            end
            WR_MEM: begin
                mem_wr = !oob_q;
                if (oob_q || mem_ready) begin
                    if (idx_q == IDX_LAST) begin
                        state_d = FINISH;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = WR_ADDR;
                    end
                end
            end
            FINISH: begin
                ack_d   = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign sd_ack       = ack_q;
    assign sd_buff_addr = baddr_q;
    assign sd_buff_dout = dout_q;
    assign mem_addr     = {lba_q, idx_q};
    assign mem_wdata    = wdata_q;
    assign busy         = (state_q != IDLE);
    assign oob_err      = oob_err_q;

endmodule

// File: tb/tb_sd_block_responder.sv
// Self-checking bench for sd_block_responder: models the initiator buffer
// RAM and a randomly stalling backing store, and checks whole blocks.
module tb_sd_block_responder;

    localparam int LBA_W     = 4;
    localparam int ACK_DELAY = 4;
    localparam int MEM_N     = 1 << (LBA_W + 9);

    logic             clk_sys = 1'b0;
    logic             RESET_n = 1'b1;
    logic [31:0]      sd_lba = '0;
    logic             sd_rd = 1'b0;
    logic             sd_wr = 1'b0;
    logic             sd_ack;
    logic [8:0]       sd_buff_addr;
    logic [7:0]       sd_buff_dout;
    logic [7:0]       sd_buff_din = '0;
    logic             sd_buff_wr;
    logic [LBA_W+8:0] mem_addr;
    logic             mem_rd;
    logic             mem_wr;
    logic [7:0]       mem_wdata;
    logic [7:0]       mem_rdata = '0;
    logic             mem_ready = 1'b0;
    logic             busy;
    logic             oob_err;

    sd_block_responder #(.LBA_W(LBA_W), .ACK_DELAY(ACK_DELAY)) dut (
        .clk_sys(clk_sys), .RESET_n(RESET_n), .sd_lba(sd_lba), .sd_rd(sd_rd),
        .sd_wr(sd_wr), .sd_ack(sd_ack), .sd_buff_addr(sd_buff_addr),
        .sd_buff_dout(sd_buff_dout), .sd_buff_din(sd_buff_din),
        .sd_buff_wr(sd_buff_wr), .mem_addr(mem_addr), .mem_rd(mem_rd),
        .mem_wr(mem_wr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_ready(mem_ready), .busy(busy), .oob_err(oob_err)
    );

    always #5 clk_sys = ~clk_sys;

    int checks = 0;
    int errors = 0;

    logic [7:0] mem     [MEM_N];  // backing store served to the DUT
    logic [7:0] ref_mem [MEM_N];  // what the store should contain
    logic [7:0] ibuf    [512];    // initiator buffer RAM

    int delay_max = 0;
    int cyc = 0;
    int rd_cycles = 0, wr_cycles = 0, held_err = 0, ack_err = 0, tim_err = 0, tim_n = 0;
    int         sq_addr[$];
    logic [7:0] sq_data[$];
    int         wq_addr[$];
    logic [7:0] wq_data[$];

    function automatic logic [7:0] exp_rd(input logic [31:0] lba, input int i);
        if ((lba >> LBA_W) != 0) return 8'hFF;
        return ref_mem[int'(lba[LBA_W-1:0]) * 512 + i];
    endfunction

    task automatic clear_obs();
        sq_addr.delete(); sq_data.delete(); wq_addr.delete(); wq_data.delete();
        rd_cycles = 0; wr_cycles = 0; held_err = 0; ack_err = 0; tim_err = 0; tim_n = 0;
    endtask

    // Initiator RAM, store responder and strobe monitor, all sampled 1 ns after each edge.
    initial begin : monitor
        logic [8:0]       last_addr;
        logic [LBA_W+8:0] pend_addr;
        logic             pend, prev_wr, chg_flag;
        int               cnt, chg_cyc;
        last_addr = '0; pend_addr = '0; pend = 1'b0; prev_wr = 1'b0;
        chg_flag = 1'b0; cnt = 0; chg_cyc = 0;
        forever begin
            @(posedge clk_sys); #1;
            cyc++;
            sd_buff_din = ibuf[last_addr];
            if (sd_buff_addr !== last_addr) begin chg_flag = 1'b1; chg_cyc = cyc; end
            last_addr = sd_buff_addr;
            if (!sd_ack) chg_flag = 1'b0;
            if (sd_buff_wr) begin
                sq_addr.push_back(int'(sd_buff_addr));
                sq_data.push_back(sd_buff_dout);
                if (!sd_ack) ack_err++;
            end
            rd_cycles += int'(mem_rd);
            wr_cycles += int'(mem_wr);
            if (mem_wr && !prev_wr && chg_flag) begin
                tim_n++;
                if (cyc - chg_cyc != 2) tim_err++;
                chg_flag = 1'b0;
            end
            prev_wr = mem_wr;
            if (!RESET_n) begin
                pend = 1'b0; mem_ready = 1'b0;
            end else if (mem_ready) begin
                mem_ready = 1'b0; mem_rdata = 8'($urandom);
            end else begin
                mem_rdata = 8'($urandom);
                if (pend) begin
                    if (!(mem_rd || mem_wr) || mem_addr !== pend_addr) held_err++;
                end else if (mem_rd || mem_wr) begin
                    pend = 1'b1; pend_addr = mem_addr;
                    cnt = int'($urandom_range(delay_max, 0));
                end
                if (pend) begin
                    if (cnt == 0) begin
                        mem_ready = 1'b1; pend = 1'b0;
                        if (mem_rd) begin
                            mem_rdata = mem[mem_addr];
                        end else begin
                            mem[mem_addr] = mem_wdata;
                            wq_addr.push_back(int'(mem_addr));
                            wq_data.push_back(mem_wdata);
                        end
                    end else begin
                        cnt--;
                    end
                end
            end
        end
    end

    // Runs one block from the current post-edge slot; idle_busy is -1 on timeout.
    task automatic do_block(input logic rd, input logic wr, input logic [31:0] lba,
                            output int acc_lat, output int ack_lat, output int idle_busy);
        int n;
        sd_lba = lba; sd_rd = rd; sd_wr = wr;
        acc_lat = 0;
        while (busy !== 1'b1 && acc_lat < 50) begin @(posedge clk_sys); #1; acc_lat++; end
        ack_lat = 0;
        while (sd_ack !== 1'b1 && ack_lat < 50) begin @(posedge clk_sys); #1; ack_lat++; end
        sd_rd = 1'b0; sd_wr = 1'b0;
        n = 0;
        while (sd_ack !== 1'b0 && n < 20000) begin @(posedge clk_sys); #1; n++; end
        idle_busy = (n >= 20000) ? -1 : int'(busy);
    endtask

    task automatic test_reset();
        #2 RESET_n = 1'b0;
        repeat (3) @(posedge clk_sys);
        #1;
        checks++;
        if ({sd_ack, sd_buff_wr, mem_rd, mem_wr, busy, oob_err} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b want 000000", {sd_ack, sd_buff_wr, mem_rd, mem_wr, busy, oob_err});
        end
        checks++;
        if (sd_buff_addr !== 9'd0 || sd_buff_dout !== 8'd0) begin
            errors++; $display("FAIL reset_buff: addr %0d dout %h want 0 0", sd_buff_addr, sd_buff_dout);
        end
        checks++;
        if (mem_addr !== '0 || mem_wdata !== 8'd0) begin
            errors++; $display("FAIL reset_mem: addr %h wdata %h want 0 0", mem_addr, mem_wdata);
        end
        RESET_n = 1'b1;
        repeat (2) @(posedge clk_sys);
        #1;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle: busy %b want 0", busy); end
    endtask

    task automatic test_read_lba0();
        int acc, lat, ib, bad;
        for (int i = 0; i < 512; i++) begin mem[i] = 8'(i) ^ 8'h5A; ref_mem[i] = 8'(i) ^ 8'h5A; end
        delay_max = 0; clear_obs();
        do_block(1'b1, 1'b0, 32'd0, acc, lat, ib);
        checks++; if (acc != 1) begin errors++; $display("FAIL rd0_accept: got %0d want 1", acc); end
        checks++; if (lat != ACK_DELAY) begin errors++; $display("FAIL rd0_ack_lat: got %0d want %0d", lat, ACK_DELAY); end
        checks++; if (ib != 0) begin errors++; $display("FAIL rd0_end_busy: got %0d want 0", ib); end
        checks++; if (sq_addr.size() != 512) begin errors++; $display("FAIL rd0_strobes: got %0d want 512", sq_addr.size()); end
        bad = 0;
        for (int i = 0; i < sq_addr.size() && i < 512; i++)
            if (sq_addr[i] != i || sq_data[i] !== (8'(i) ^ 8'h5A)) bad++;
        checks++; if (bad != 0) begin errors++; $display("FAIL rd0_data: %0d bad bytes want 0", bad); end
        checks++; if (ack_err != 0) begin errors++; $display("FAIL rd0_strobe_ack: %0d strobes without ack want 0", ack_err); end
    endtask

    task automatic test_write_lba3();
        int acc, lat, ib, bad;
        for (int i = 0; i < 512; i++) ibuf[i] = ~8'(i);
        delay_max = 0; clear_obs();
        do_block(1'b0, 1'b1, 32'd3, acc, lat, ib);
        for (int i = 0; i < 512; i++) ref_mem[3 * 512 + i] = ibuf[i];
        checks++; if (lat != ACK_DELAY || ib != 0) begin errors++; $display("FAIL wr3_timing: ack_lat %0d end %0d want %0d 0", lat, ib, ACK_DELAY); end
        checks++; if (wq_addr.size() != 512) begin errors++; $display("FAIL wr3_count: got %0d want 512", wq_addr.size()); end
        bad = 0;
        for (int i = 0; i < wq_addr.size() && i < 512; i++)
            if (wq_addr[i] != 'h600 + i || wq_data[i] !== ~8'(i)) bad++;
        checks++; if (bad != 0) begin errors++; $display("FAIL wr3_data: %0d bad writes want 0", bad); end
        checks++;
        if (tim_err != 0 || tim_n < 511) begin
            errors++; $display("FAIL wr3_sample_delay: %0d off of %0d want 0 of >=511", tim_err, tim_n);
        end
        checks++; if (sq_addr.size() != 0) begin errors++; $display("FAIL wr3_no_strobe: got %0d want 0", sq_addr.size()); end
    endtask

    task automatic test_sequencer();
        int acc, lat, ib, bad_hs, bad;
        for (int a = 0; a < MEM_N; a++) begin mem[a] = 8'($urandom); ref_mem[a] = mem[a]; end
        delay_max = 0; clear_obs(); bad_hs = 0;
        for (int b = 0; b < 16; b++) begin
            do_block(1'b1, 1'b0, 32'(b), acc, lat, ib);
            // accept on the first IDLE cycle after the fall, so ack is low for acc+lat >= 1 cycles
            if (acc != 1 || lat != ACK_DELAY || ib != 0 || acc + lat < 1) bad_hs++;
        end
        checks++; if (bad_hs != 0) begin errors++; $display("FAIL seq_handshake: %0d bad blocks want 0", bad_hs); end
        checks++; if (sq_addr.size() != 8192) begin errors++; $display("FAIL seq_strobes: got %0d want 8192", sq_addr.size()); end
        bad = 0;
        for (int k = 0; k < sq_addr.size() && k < 8192; k++)
            if (sq_addr[k] != k % 512 || sq_data[k] !== exp_rd(32'(k / 512), k % 512)) bad++;
        checks++; if (bad != 0) begin errors++; $display("FAIL seq_data: %0d bad bytes want 0", bad); end
    endtask

    task automatic test_oob();
        int acc, lat, ib, bad;
        logic [31:0] lba;
        delay_max = 2; clear_obs();
        do_block(1'b1, 1'b0, 32'd16, acc, lat, ib);
        checks++; if (oob_err !== 1'b1) begin errors++; $display("FAIL oob_flag: got %b want 1", oob_err); end
        checks++; if (rd_cycles != 0) begin errors++; $display("FAIL oob_no_mem_rd: got %0d want 0", rd_cycles); end
        checks++; if (lat != ACK_DELAY || ib != 0) begin errors++; $display("FAIL oob_timing: ack_lat %0d end %0d want %0d 0", lat, ib, ACK_DELAY); end
        bad = (sq_addr.size() == 512) ? 0 : 1000;
        for (int i = 0; i < sq_addr.size() && i < 512; i++)
            if (sq_addr[i] != i || sq_data[i] !== 8'hFF) bad++;
        checks++; if (bad != 0) begin errors++; $display("FAIL oob_fill: %0d bad (size %0d) want 0", bad, sq_addr.size()); end

        lba = 32'($urandom_range(15, 0));
        clear_obs();
        do_block(1'b1, 1'b0, lba, acc, lat, ib);
        bad = (sq_addr.size() == 512) ? 0 : 1000;
        for (int i = 0; i < sq_addr.size() && i < 512; i++)
            if (sq_addr[i] != i || sq_data[i] !== exp_rd(lba, i)) bad++;
        checks++; if (bad != 0) begin errors++; $display("FAIL oob_next_read: %0d bad want 0", bad); end
        checks++; if (oob_err !== 1'b1) begin errors++; $display("FAIL oob_sticky: got %b want 1", oob_err); end

        for (int i = 0; i < 512; i++) ibuf[i] = 8'($urandom);
        clear_obs();
        do_block(1'b0, 1'b1, 32'hFFFF_FFF0, acc, lat, ib);
        bad = 0;
        for (int a = 0; a < MEM_N; a++) if (mem[a] !== ref_mem[a]) bad++;
        checks++;
        if (wr_cycles != 0 || bad != 0 || ib != 0) begin
            errors++; $display("FAIL oob_write: mem_wr %0d changed %0d end %0d want 0 0 0", wr_cycles, bad, ib);
        end
    endtask

    task automatic test_random_delay();
        int acc, lat, ib, bad;
        logic [31:0] lba;
        delay_max = 7; clear_obs();
        lba = 32'($urandom_range(15, 0));
        do_block(1'b1, 1'b0, lba, acc, lat, ib);
        bad = (sq_addr.size() == 512) ? 0 : 1000;
        for (int i = 0; i < sq_addr.size() && i < 512; i++)
            if (sq_addr[i] != i || sq_data[i] !== exp_rd(lba, i)) bad++;
        checks++; if (bad != 0) begin errors++; $display("FAIL rnd_read_data: %0d bad want 0", bad); end
        checks++; if (held_err != 0) begin errors++; $display("FAIL rnd_read_hold: %0d drops want 0", held_err); end

        for (int i = 0; i < 512; i++) ibuf[i] = 8'($urandom);
        clear_obs();
        lba = 32'($urandom_range(15, 0));
        do_block(1'b0, 1'b1, lba, acc, lat, ib);
        for (int i = 0; i < 512; i++) ref_mem[int'(lba) * 512 + i] = ibuf[i];
        bad = (wq_addr.size() == 512) ? 0 : 1000;
        for (int i = 0; i < wq_addr.size() && i < 512; i++)
            if (wq_addr[i] != int'(lba) * 512 + i || wq_data[i] !== ibuf[i]) bad++;
        for (int a = 0; a < MEM_N; a++) if (mem[a] !== ref_mem[a]) bad++;
        checks++; if (bad != 0) begin errors++; $display("FAIL rnd_write_data: %0d bad want 0", bad); end
        checks++; if (held_err != 0 || tim_err != 0) begin errors++; $display("FAIL rnd_write_hold: drops %0d timing %0d want 0 0", held_err, tim_err); end
    endtask

    task automatic test_reset_mid();
        int acc, lat, ib, bad, n;
        logic [31:0] lba;
        delay_max = 3; clear_obs();
        lba = 32'($urandom_range(15, 0));
        sd_lba = lba; sd_rd = 1'b1;
        n = 0;
        while (sd_ack !== 1'b1 && n < 50) begin @(posedge clk_sys); #1; n++; end
        sd_rd = 1'b0;
        while (sq_addr.size() < 100 && n < 5000) begin @(posedge clk_sys); #1; n++; end
        #3 RESET_n = 1'b0;
        #1;
        checks++;
        if (sq_addr.size() != 100 || sd_ack !== 1'b0 || busy !== 1'b0 || mem_rd !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_abort: strobes %0d ack %b busy %b mem_rd %b want 100 0 0 0", sq_addr.size(), sd_ack, busy, mem_rd);
        end
        checks++; if (oob_err !== 1'b0) begin errors++; $display("FAIL mid_reset_oob_clear: got %b want 0", oob_err); end
        repeat (2) @(posedge clk_sys);
        #1 RESET_n = 1'b1;
        @(posedge clk_sys); #1;
        clear_obs();
        do_block(1'b1, 1'b0, lba, acc, lat, ib);
        bad = (sq_addr.size() == 512) ? 0 : 1000;
        for (int i = 0; i < sq_addr.size() && i < 512; i++)
            if (sq_addr[i] != i || sq_data[i] !== exp_rd(lba, i)) bad++;
        checks++; if (bad != 0 || lat != ACK_DELAY) begin errors++; $display("FAIL mid_reset_restart: %0d bad ack_lat %0d want 0 %0d", bad, lat, ACK_DELAY); end
    endtask

    task automatic test_both_req();
        int acc, lat, ib, bad;
        logic [31:0] lba;
        delay_max = 1; clear_obs();
        lba = 32'($urandom_range(15, 0));
        do_block(1'b1, 1'b1, lba, acc, lat, ib);
        bad = (sq_addr.size() == 512) ? 0 : 1000;
        for (int i = 0; i < sq_addr.size() && i < 512; i++)
            if (sq_addr[i] != i || sq_data[i] !== exp_rd(lba, i)) bad++;
        checks++; if (bad != 0) begin errors++; $display("FAIL both_read: %0d bad want 0", bad); end
        checks++;
        if (wr_cycles != 0 || wq_addr.size() != 0) begin
            errors++; $display("FAIL both_no_write: mem_wr %0d writes %0d want 0 0", wr_cycles, wq_addr.size());
        end
    endtask

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int a = 0; a < MEM_N; a++) begin mem[a] = 8'($urandom); ref_mem[a] = mem[a]; end
        for (int i = 0; i < 512; i++) ibuf[i] = 8'h00;
        test_reset();
        test_read_lba0();
        test_write_lba3();
        test_sequencer();
        test_oob();
        test_random_delay();
        test_reset_mid();
        test_both_req();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sd_block_responder.md
Name: sd_block_responder

Overview:
- Device end of the SD block-buffer handshake used by the backup-RAM save/load sequencer.
- Accepts sd_rd/sd_wr block requests at sd_lba and raises sd_ack for the duration of the transfer.
- Moves 512 bytes per block:
  - read: streams bytes into the initiator's buffer via sd_buff_addr/sd_buff_dout/sd_buff_wr.
  - write: collects bytes from sd_buff_din.
- The backing byte store sits behind a simple stall-capable memory port.
- Used as the simulation and standalone SD model in place of the firmware-side SPI path.

Parameters:
LBA_W, 4, block-index width of the backing store (16 blocks = 8 KB).
ACK_DELAY, 4, cycles from request acceptance to sd_ack rise (minimum 1).

Ports:
clk_sys  in  1  system clock; all logic on posedge.
RESET_n  in  1  asynchronous active-low reset.
sd_lba  in  32  block address; sampled at acceptance.
sd_rd  in  1  read request (level).
sd_wr  in  1  write request (level).
sd_ack  out  1  transfer-in-progress acknowledge.
sd_buff_addr  out  9  byte index within block.
sd_buff_dout  out  8  read data to initiator buffer.
sd_buff_din  in  8  write data from initiator buffer (registered-read RAM).
sd_buff_wr  out  1  one-cycle strobe: sd_buff_dout valid for sd_buff_addr.
mem_addr  out  LBA_W+9  backing store byte address {lba[LBA_W-1:0], byte index}.
mem_rd  out  1  read request, held until mem_ready.
mem_wr  out  1  write request, held until mem_ready.
mem_wdata  out  8  write data.
mem_rdata  in  8  read data, valid with mem_ready.
mem_ready  in  1  one-cycle completion pulse.
busy  out  1  high in any state other than IDLE.
oob_err  out  1  sticky: a request with lba >= 2**LBA_W occurred.

Behaviour:
- Reset: every output is 0 and the state is IDLE. Reset is asynchronous and aborts any transfer instantly with no completion. A new request after reset starts at byte 0.
- States: IDLE, ACKWAIT, RD_REQ, RD_STB, WR_ADDR, WR_WAIT, WR_CAP, WR_MEM, FINISH.
- IDLE:
  - A request is accepted when (sd_rd|sd_wr) and !sd_ack.
  - Latch lba and dir (rd wins if both are high). Clear the byte index and load the delay counter with ACK_DELAY-1.
  - Go to ACKWAIT.
- ACKWAIT:
  - Count down; at 0, set sd_ack=1.
  - Go to RD_REQ or WR_ADDR.
  - The initiator drops its request on the ack rise. Request level is ignored until IDLE.
- sd_ack stays 1 from ACKWAIT exit through the FINISH cycle. Every sd_buff_wr pulse occurs with sd_ack=1.
- Read path:
  - RD_REQ: mem_rd=1, mem_addr={lba,idx}. On mem_ready, register mem_rdata into sd_buff_dout and go to RD_STB.
  - RD_STB: sd_buff_wr=1 for exactly one cycle, sd_buff_addr=idx. If idx==511 go to FINISH; else idx+1 and go to RD_REQ.
  - sd_buff_dout and sd_buff_addr hold their values between strobes.
- Write path:
  - WR_ADDR: drive sd_buff_addr=idx.
  - WR_WAIT: one cycle for the RAM address register.
  - WR_CAP: sample sd_buff_din into mem_wdata. Sampling occurs 2 cycles after sd_buff_addr changes.
  - WR_MEM: mem_wr=1 until mem_ready. Then, if idx==511, go to FINISH; else idx+1 and go to WR_ADDR.
- Out of range (lba[31:LBA_W] != 0):
  - Set oob_err.
  - No mem_rd or mem_wr is ever asserted.
  - Read bytes are 8'hFF; RD_REQ completes in 1 cycle.
  - Write bytes are captured and discarded; WR_MEM completes in 1 cycle.
  - The full 512-byte handshake still runs.
- FINISH:
  - Drive sd_ack=0 and go to IDLE.
  - A request raised on the ack falling edge is accepted in the next IDLE cycle. This gives back-to-back blocks with ≥1 cycle of sd_ack low.
- Index arithmetic: 9-bit; wrap is never reached because 511 terminates the block.
- mem_ready while no request is outstanding is ignored.
- oob_err is cleared only by reset.

Decomposition:
- Package sd_block_pkg holds:
  - state enum;
  - BLK_BYTES=512;
  - IDX_W=9;
  - RD_FILL=8'hFF.
- No sub-module: a single FSM with a byte counter and a delay counter. The memory port is designed to connect directly to dpram/spram port B in benches.

Test Plan:
- Read lba 0, mem[i]=i^8'h5A, mem_ready 1 cycle after request: sd_ack rises 4 cycles after accept; 512 sd_buff_wr pulses, addr 0..511, dout=i^5A; then sd_ack falls and busy=0.
- Write lba 3, initiator RAM[i]=~i: mem_wr at addresses 0x600..0x7FF with mem_wdata=~i; sd_buff_din sampled 2 cycles after each addr change.
- Sequencer loop lba 0..15 with load, request re-raised on each ack fall: 16 blocks complete, each ack-low gap ≥1 cycle, no dropped request; 8192 strobes total.
- Read lba 16: oob_err=1, zero mem_rd cycles, 512 strobes of 8'hFF, normal ack timing; oob_err persists into the next valid read.
- mem_ready delayed 0–7 random cycles: data order is preserved and each mem_rd is held until ready. Reset at byte 100: sd_ack=0 at once; the next read restarts at byte 0.
- sd_rd and sd_wr high together: a read is performed; no mem_wr is asserted.
